rv32im_pc_seq: RTL and testbench
================================

# rv32im_pc_seq

Program-counter sequencer and fetch controller for the rv32im core. Owns the architectural PC register and issues single-outstanding word fetches to instruction memory. Presents each fetched instruction and its PC to decode with a valid/ready handshake. Applies redirects resolved by the branch unit (`rv32im_br`), discarding any wrong-path fetch in flight.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.

Ports:
- `clk_i` in 1: single core clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `if_req_o` out 1: fetch request.
- `if_addr_o` out `API_ADDR_WIDTH`: fetch word address.
- `if_gnt_i` in 1: memory accepted the request this cycle.
- `if_rvalid_i` in 1: fetch data valid.
- `if_rdata_i` in `API_DATA_WIDTH`: fetched instruction.
- `id_valid_o` out 1: instruction available to decode.
- `id_ready_i` in 1: decode accepts.
- `id_instr_o` out `API_DATA_WIDTH`: instruction.
- `id_pc_o` out `API_ADDR_WIDTH`: PC of `id_instr_o`.
- `br_redirect_i` in 1: branch unit resolved a taken branch or jump this cycle.
- `br_target_i` in `API_ADDR_WIDTH`: redirect target (`br_pc_o` of `rv32im_br`).
- `exc_misalign_o` out 1: misaligned-target trap (see Configuration).
- `exc_addr_o` out `API_ADDR_WIDTH`: offending target.

## Operation

- States:
  - IDLE: post-reset.
  - REQ: `if_req_o` high.
  - WAIT: granted, awaiting data.
  - HOLD: instruction held for decode.
  - TRAP: macro builds only.
- IDLE -> REQ unconditionally.
- REQ -> WAIT on `if_gnt_i`. `if_addr_o` and `if_req_o` must stay stable until the grant.
- WAIT -> HOLD on `if_rvalid_i` with kill flag clear. On that edge:
  - `if_rdata_i` is captured into `id_instr_o`.
  - `id_pc_o` = fetch PC.
  - fetch PC += 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- WAIT -> REQ on `if_rvalid_i` with kill flag set. Data is dropped and the kill flag is cleared.
- HOLD -> REQ when `id_valid_o && id_ready_i`.
- Redirect (`br_redirect_i` high):
  - In IDLE or HOLD: fetch PC <= `br_target_i`, next state REQ. The held instruction is discarded.
  - In REQ with no grant this cycle: request stays stable, fetch PC <= target, kill flag set; the response will be discarded.
  - In REQ with a grant this cycle: same as above.
  - In WAIT without rvalid: kill flag set, fetch PC <= target.
  - In WAIT with rvalid the same cycle: data discarded, next state REQ at target.
- `id_valid_o` = (state == HOLD) && !`br_redirect_i`. A redirect always overrides a same-cycle decode handshake.
- Exactly one request is outstanding. No instruction is ever presented twice or out of order.
- Reset mid-operation: all state returns to reset values at the next edge. A later `if_rvalid_i` for the abandoned request is ignored in IDLE and REQ.

## Timing

- Reset values:
  - `if_req_o` 0, `if_addr_o` `RESET_PC`.
  - `id_valid_o` 0, `id_instr_o` 32'h0000_0013 (NOP), `id_pc_o` 0.
  - `exc_misalign_o` 0, `exc_addr_o` 0, kill flag 0, state IDLE.
- First edge with `rst_ni` high: IDLE -> REQ. `if_req_o` is high from that cycle.
- `if_rvalid_i` at cycle N -> `id_valid_o` high at N+1.
- Zero-wait memory (grant in the request cycle, rvalid one cycle later, decode always ready) gives peak throughput of one instruction per 3 cycles.
- Redirect at cycle N in HOLD -> `if_req_o` with `if_addr_o` = target at N+1.

## Configuration

- Macro `API_PC_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `br_target_i[1:0] != 0` enters TRAP and captures `exc_addr_o` = target.
  - `exc_misalign_o` stays high until reset; `if_req_o` and `id_valid_o` stay low in TRAP.
  - An in-flight response is ignored.
- Undefined:
  - `br_target_i[1:0]` is forced to 2'b00.
  - TRAP does not exist; `exc_misalign_o` and `exc_addr_o` are tied to 0.

## Structure

- Shared `DEFINITIONS.v` gains:
  - `PCSEQ_STATE_WIDTH` and the state encodings `PCSEQ_IDLE`, `_REQ`, `_WAIT`, `_HOLD`, `_TRAP`.
  - `API_NOP_INSTR` (32'h0000_0013).
  - `API_PC_STEP` (4).
- Existing `API_ADDR_WIDTH` and `API_DATA_WIDTH` are reused.
- Single module, no sub-module. `rv32im_br` is instantiated by the parent, not inside this block.

## Test plan

- Reset release, memory grants immediately with rvalid next cycle, decode always ready -> fetches at 0x0, 0x4, 0x8 in order. Each `id_pc_o` matches, `id_valid_o` is one cycle per instruction, 3-cycle spacing.
- Decode holds `id_ready_i` low for 5 cycles in HOLD -> `id_instr_o`/`id_pc_o` stable. No new `if_req_o` until accepted.
- Redirect to 0x0000_0100 while in WAIT -> stale rvalid data never reaches decode. Next request is at 0x100, then `id_pc_o` = 0x100.
- Redirect to 0x200 in the same cycle as `id_ready_i` high in HOLD -> held instruction not accepted (`id_valid_o` low). Next fetch at 0x200.
- PC 0xFFFF_FFFC fetch completes -> next request address 0x0000_0000.
- With macro, redirect to 0x0000_0102 -> `exc_misalign_o` 1, `exc_addr_o` 0x102, no further requests until reset. Without macro -> fetch at 0x100.

Source files
------------

// File: rtl/rv32im_pc_seq_pkg.sv
// rv32im_pc_seq shared types: widths, fetch constants, sequencer states.
// Optional misaligned-target trap is enabled by API_PC_MISALIGN_TRAP_EN.
package rv32im_pc_seq_pkg;

  localparam int API_ADDR_WIDTH    = 32;
  localparam int API_DATA_WIDTH    = 32;
  localparam int PCSEQ_STATE_WIDTH = 3;

  typedef logic [API_ADDR_WIDTH-1:0] addr_t;
  typedef logic [API_DATA_WIDTH-1:0] data_t;

  localparam data_t API_NOP_INSTR = 32'h0000_0013;
  localparam addr_t API_PC_STEP   = 32'd4;

  typedef enum logic [PCSEQ_STATE_WIDTH-1:0] {
    PCSEQ_IDLE = 3'd0,
    PCSEQ_REQ  = 3'd1,
    PCSEQ_WAIT = 3'd2,
    PCSEQ_HOLD = 3'd3,
    PCSEQ_TRAP = 3'd4
  } pcseq_state_e;

  typedef struct packed {
    data_t instr;
    addr_t pc;
  } id_bundle_t;

  function automatic addr_t word_align(addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/rv32im_pc_seq_if.sv
// Fetch bus and decode handshake between the PC sequencer and its peers.
// master = sequencer side, slave = memory/decode side.
interface rv32im_pc_seq_if;
  import rv32im_pc_seq_pkg::*;

  logic  if_req_o;
  addr_t if_addr_o;
  logic  if_gnt_i;
  logic  if_rvalid_i;
  data_t if_rdata_i;

  logic  id_valid_o;
  logic  id_ready_i;
  data_t id_instr_o;
  addr_t id_pc_o;

  modport master (
    output if_req_o,
    output if_addr_o,
    input  if_gnt_i,
    input  if_rvalid_i,
    input  if_rdata_i,
    output id_valid_o,
    input  id_ready_i,
    output id_instr_o,
    output id_pc_o
  );

  modport slave (
    input  if_req_o,
    input  if_addr_o,
    output if_gnt_i,
    output if_rvalid_i,
    output if_rdata_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_instr_o,
    input  id_pc_o
  );

endinterface

// File: rtl/rv32im_pc_seq.sv
// PC sequencer: single-outstanding fetch, decode hold, branch redirect.
// Define API_PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module rv32im_pc_seq
  import rv32im_pc_seq_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rv32im_pc_seq_if.master bus,
  input  logic            br_redirect_i,
  input  addr_t           br_target_i,
  output logic            exc_misalign_o,
  output addr_t           exc_addr_o
);

  pcseq_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        addr_q, addr_d;
  logic         kill_q, kill_d;
  id_bundle_t   id_q, id_d;

  logic  redir;
  logic  trap_go;
  addr_t tgt;

  assign redir = br_redirect_i && (state_q != PCSEQ_TRAP);

`ifdef API_PC_MISALIGN_TRAP_EN
  assign tgt     = br_target_i;
  assign trap_go = redir && (br_target_i[1:0] != 2'b00);
`else
  assign tgt     = word_align(br_target_i);
  assign trap_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    id_d    = id_q;

    unique case (state_q)
      PCSEQ_IDLE: state_d = PCSEQ_REQ;
      PCSEQ_REQ: begin
        if (bus.if_gnt_i) state_d = PCSEQ_WAIT;
      end
      PCSEQ_WAIT: begin
        if (bus.if_rvalid_i) begin
          if (kill_q || redir) begin
            state_d = PCSEQ_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d  = PCSEQ_HOLD;
            id_d     = '{instr: bus.if_rdata_i, pc: addr_q};
            pc_d     = addr_q + API_PC_STEP;
          end
        end
      end
      PCSEQ_HOLD: begin
        if (bus.id_ready_i) state_d = PCSEQ_REQ;
      end
      PCSEQ_TRAP: state_d = PCSEQ_TRAP;
      default:    state_d = PCSEQ_IDLE;
    endcase

    // A request already on the bus must complete; its data is killed.
    if (redir) begin
      pc_d = tgt;
      if (state_q == PCSEQ_REQ) begin
        kill_d = 1'b1;
      end else if (state_q == PCSEQ_WAIT) begin
        if (!bus.if_rvalid_i) kill_d = 1'b1;
      end else begin
        state_d = PCSEQ_REQ;
      end
    end

    if (trap_go) state_d = PCSEQ_TRAP;

    if (state_d == PCSEQ_REQ && state_q != PCSEQ_REQ) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= PCSEQ_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      id_q    <= '{instr: API_NOP_INSTR, pc: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      id_q    <= id_d;
    end
  end

  assign bus.if_req_o   = (state_q == PCSEQ_REQ);
  assign bus.if_addr_o  = addr_q;
  assign bus.id_valid_o = (state_q == PCSEQ_HOLD) && !br_redirect_i;
  assign bus.id_instr_o = id_q.instr;
  assign bus.id_pc_o    = id_q.pc;

`ifdef API_PC_MISALIGN_TRAP_EN
  logic  exc_q, exc_d;
  addr_t exc_addr_q, exc_addr_d;

  always_comb begin
    exc_d      = exc_q | trap_go;
    exc_addr_d = trap_go ? br_target_i : exc_addr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign exc_misalign_o = exc_q;
  assign exc_addr_o     = exc_addr_q;
`else
  assign exc_misalign_o = 1'b0;
  assign exc_addr_o     = '0;
`endif

endmodule

// File: tb/tb_rv32im_pc_seq.sv
// Scoreboard bench for rv32im_pc_seq: random memory/decode/redirects.
// Expected PC stream comes from a sequential-program model.
module tb_rv32im_pc_seq;
  import rv32im_pc_seq_pkg::*;

  localparam addr_t RPC = 32'h0000_0000;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  br_redirect = 1'b0;
  addr_t br_target = '0;
  logic  exc_mis;
  addr_t exc_addr;

  int total = 0;
  int bad = 0;

  rv32im_pc_seq_if bus();

  rv32im_pc_seq #(.RESET_PC(RPC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus),
    .br_redirect_i  (br_redirect),
    .br_target_i    (br_target),
    .exc_misalign_o (exc_mis),
    .exc_addr_o     (exc_addr)
  );

  always #5 clk = ~clk;

  function automatic data_t instr_of(addr_t a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // stimulus knobs and memory model
  int    gnt_pct = 100;
  int    rdy_pct = 100;
  int    red_pct = 0;
  int    max_lat = 0;
  logic  pend = 1'b0;
  addr_t paddr = '0;
  int    lat = 0;
  logic  zw = 1'b0;
  addr_t redir_q[$];

  task automatic redirect(input addr_t t);
    br_redirect = 1'b1;
    br_target = t;
    redir_q.push_back(t);
  endtask

  function automatic addr_t rand_tgt();
    addr_t t;
    case ($urandom_range(2))
      0: t = 32'($urandom_range(255)) << 2;
      1: t = 32'hffff_fff0 + (32'($urandom_range(3)) << 2);
      default: t = $urandom;
    endcase
`ifdef API_PC_MISALIGN_TRAP_EN
    t = t & ~32'h3;
`endif
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.if_rvalid_i = 1'b0;
    bus.if_rdata_i = $urandom;
    if (pend) begin
      if (lat == 0) begin
        bus.if_rvalid_i = 1'b1;
        bus.if_rdata_i = instr_of(paddr);
        pend = 1'b0;
      end else begin
        lat--;
      end
    end
    bus.if_gnt_i = 1'b0;
    if (bus.if_req_o && !pend && $urandom_range(99) < gnt_pct) begin
      bus.if_gnt_i = 1'b1;
      pend = 1'b1;
      paddr = bus.if_addr_o;
      lat = $urandom_range(max_lat);
    end
    bus.id_ready_i = $urandom_range(99) < rdy_pct;
    br_redirect = 1'b0;
    if (rst_n && $urandom_range(99) < red_pct) redirect(rand_tgt());
  endtask

  // monitor: reference program model + protocol checks
  int    cyc = 0;
  int    n_acc = 0;
  int    last_v = -1;
  addr_t exp_pc = RPC;
  addr_t last_acc_pc = '0;
  logic  prev_req = 1'b0;
  logic  prev_gnt = 1'b0;
  logic  prev_stall = 1'b0;
  addr_t prev_addr = '0;
  data_t prev_instr = '0;
  addr_t prev_pc = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_pc = RPC;
      redir_q.delete();
      last_v = -1;
      prev_req = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_req && !prev_gnt && !exc_mis) begin
        chk("req_held", 32'(bus.if_req_o), 32'd1);
        chk("addr_held", bus.if_addr_o, prev_addr);
      end
      if (prev_stall && !br_redirect) begin
        chk("hold_valid", 32'(bus.id_valid_o), 32'd1);
        chk("hold_instr", bus.id_instr_o, prev_instr);
        chk("hold_pc", bus.id_pc_o, prev_pc);
      end
      if (bus.id_valid_o) chk("req_in_hold", 32'(bus.if_req_o), 32'd0);
      if (br_redirect) begin
        chk("redir_masks_valid", 32'(bus.id_valid_o), 32'd0);
        last_v = -1;
        if (redir_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL redir_queue: got empty want entry");
        end else begin
          exp_pc = redir_q.pop_front() & ~32'h3;
        end
      end else if (bus.id_valid_o && bus.id_ready_i) begin
        chk("id_pc", bus.id_pc_o, exp_pc);
        chk("id_instr", bus.id_instr_o, instr_of(exp_pc));
        if (zw && last_v >= 0) chk("spacing", 32'(cyc - last_v), 32'd3);
        last_v = cyc;
        last_acc_pc = bus.id_pc_o;
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      prev_req = bus.if_req_o;
      prev_gnt = bus.if_gnt_i;
      prev_addr = bus.if_addr_o;
      prev_stall = bus.id_valid_o && !bus.id_ready_i;
      prev_instr = bus.id_instr_o;
      prev_pc = bus.id_pc_o;
    end
  end

  task automatic wait_acc(input string nm, input int k);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (n_acc > k) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo(nm);
  endtask

  initial begin
    logic  found;
    addr_t hp;
    int    k;

    bus.if_gnt_i = 1'b0;
    bus.if_rvalid_i = 1'b0;
    bus.if_rdata_i = '0;
    bus.id_ready_i = 1'b0;

    repeat (3) step();
    chk("rst_req", 32'(bus.if_req_o), 32'd0);
    chk("rst_addr", bus.if_addr_o, RPC);
    chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
    chk("rst_instr", bus.id_instr_o, 32'h0000_0013);
    chk("rst_pc", bus.id_pc_o, 32'd0);
    chk("rst_exc", 32'(exc_mis), 32'd0);
    chk("rst_exc_addr", exc_addr, 32'd0);

    // zero-wait stream from reset
    rst_n = 1'b1;
    zw = 1'b1;
    step();
    chk("req_after_rst", 32'(bus.if_req_o), 32'd1);
    chk("addr_after_rst", bus.if_addr_o, RPC);
    repeat (14) step();
    chk("zw_count", 32'(n_acc >= 4), 32'd1);
    zw = 1'b0;

    // decode stall
    rdy_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.id_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tmo("stall_wait");
    end else begin
      hp = bus.id_pc_o;
      repeat (5) begin
        step();
        chk("stall_req", 32'(bus.if_req_o), 32'd0);
        chk("stall_pc", bus.id_pc_o, hp);
      end
    end
    rdy_pct = 100;

    // redirect while waiting for data
    max_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pend && !bus.if_req_o && !bus.id_valid_o) begin
        redirect(32'h0000_0100);
        found = 1'b1;
        break;
      end
    end
    if (!found) tmo("wait_redir");
    k = n_acc;
    wait_acc("wait_redir_acc", k);
    chk("wait_redir_pc", last_acc_pc, 32'h0000_0100);

    // redirect against a same-cycle decode accept
    max_lat = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.id_valid_o) begin
        redirect(32'h0000_0200);
        found = 1'b1;
        break;
      end
    end
    if (!found) tmo("hold_redir");
    k = n_acc;
    wait_acc("hold_redir_acc", k);
    chk("hold_redir_pc", last_acc_pc, 32'h0000_0200);

    // address wrap
    step();
    redirect(32'hffff_fff8);
    zw = 1'b1;
    k = n_acc;
    for (int j = 0; j < 4; j++) wait_acc("wrap_acc", k + j);
    chk("wrap_pc", last_acc_pc, 32'h0000_0004);
    zw = 1'b0;

    // misaligned target
    step();
    redirect(32'h0000_0102);
`ifdef API_PC_MISALIGN_TRAP_EN
    repeat (8) begin
      step();
      chk("trap_flag", 32'(exc_mis), 32'd1);
      chk("trap_addr", exc_addr, 32'h0000_0102);
      chk("trap_noreq", 32'(bus.if_req_o), 32'd0);
      chk("trap_novalid", 32'(bus.id_valid_o), 32'd0);
    end
`else
    k = n_acc;
    wait_acc("misalign_acc", k);
    chk("misalign_pc", last_acc_pc, 32'h0000_0100);
    chk("exc_tied", 32'(exc_mis), 32'd0);
`endif
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // random traffic with a mid-run reset
    gnt_pct = 60;
    rdy_pct = 70;
    red_pct = 8;
    max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      step();
    end
    red_pct = 0;
    repeat (10) step();
    chk("progress", 32'(n_acc > 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
